// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants for the seven-segment display front end:
//   - active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   - blank pattern and all-anodes-off constant
//   - source index encoding for the eight debug sources
//   - hex_to_seg() helper mapping a nibble to its segment pattern
// -----------------------------------------------------------------------------
package display_pkg;

    typedef logic [2:0] src_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam src_idx_t SRC_CTRL   = 3'd0;
    localparam src_idx_t SRC_INSTR  = 3'd1;
    localparam src_idx_t SRC_RS     = 3'd2;
    localparam src_idx_t SRC_RT     = 3'd3;
    localparam src_idx_t SRC_RDATA  = 3'd4;
    localparam src_idx_t SRC_RFIN   = 3'd5;
    localparam src_idx_t SRC_PC     = 3'd6;
    localparam src_idx_t SRC_ALUOUT = 3'd7;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = SEG_HEX_0;
            4'h1: pat = SEG_HEX_1;
            4'h2: pat = SEG_HEX_2;
            4'h3: pat = SEG_HEX_3;
            4'h4: pat = SEG_HEX_4;
            4'h5: pat = SEG_HEX_5;
            4'h6: pat = SEG_HEX_6;
            4'h7: pat = SEG_HEX_7;
            4'h8: pat = SEG_HEX_8;
            4'h9: pat = SEG_HEX_9;
            4'hA: pat = SEG_HEX_A;
            4'hB: pat = SEG_HEX_B;
            4'hC: pat = SEG_HEX_C;
            4'hD: pat = SEG_HEX_D;
            4'hE: pat = SEG_HEX_E;
            default: pat = SEG_HEX_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes a raw push-button into clk, debounces it and emits a one-cycle
// pulse when the debounced level rises.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   btn        : raw button, asynchronous to clk
//   rise       : one-cycle pulse on the clock edge the debounced level goes 0->1
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] stable_cnt_reg;
    logic             level_reg;
    logic             rise_reg;

    // A sample differing from the current level counts toward a change; the
    // DEBOUNCE_CYCLES-th consecutive one flips the level. Any agreeing sample
    // restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            stable_cnt_reg <= '0;
            level_reg      <= 1'b0;
            rise_reg       <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (stable_cnt_reg == CNT_LAST) begin
                    level_reg      <= sync2_reg;
                    stable_cnt_reg <= '0;
                    rise_reg       <= sync2_reg;
                end else begin
                    stable_cnt_reg <= stable_cnt_reg + 1'b1;
                end
            end else begin
                stable_cnt_reg <= '0;
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Seven-segment front end for the processor demo. A debounced button steps
// through eight debug sources; the selected value is snapshotted once per scan
// and multiplexed as hex onto a 4-digit common-anode display.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   sel_btn         : raw source-select button (active-high, async)
//   ctrl_sig..rfin_lsh : 16-bit debug sources 0..5
//   pc_lsb, aluout_lsb : 8-bit debug sources 6, 7 (zero-extended)
//   seg             : cathodes {g,f,e,d,c,b,a}, active-low
//   dp              : decimal point, active-low (marks the 8-bit view)
//   an              : anodes, active-low, an[0] rightmost
//   src_led         : one-hot selected source
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_BITS    = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_btn,
    input  logic [15:0] ctrl_sig,
    input  logic [15:0] instr_lsh,
    input  logic [15:0] rs_lsh,
    input  logic [15:0] rt_lsh,
    input  logic [15:0] rdata_lsh,
    input  logic [15:0] rfin_lsh,
    input  logic [7:0]  pc_lsb,
    input  logic [7:0]  aluout_lsb,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [7:0]  src_led
);

    logic [REFRESH_BITS-1:0] refresh_cnt_reg;
    logic [1:0]              digit_idx_reg;
    src_idx_t                src_idx_reg;
    logic [15:0]             snapshot_reg;
    logic                    first_cycle_reg;
    logic [3:0]              an_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [7:0]              src_led_reg;

    logic        btn_rise;
    logic [15:0] src_bus [8];
    logic [3:0]  nibble [4];
    logic [7:0]  src_led_next;
    logic [6:0]  seg_next;
    logic        dp_next;
    logic        refresh_wrap;
    logic        scan_wrap;
    logic        wide_view;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .btn  (sel_btn),
        .rise (btn_rise)
    );

    assign src_bus[SRC_CTRL]   = ctrl_sig;
    assign src_bus[SRC_INSTR]  = instr_lsh;
    assign src_bus[SRC_RS]     = rs_lsh;
    assign src_bus[SRC_RT]     = rt_lsh;
    assign src_bus[SRC_RDATA]  = rdata_lsh;
    assign src_bus[SRC_RFIN]   = rfin_lsh;
    assign src_bus[SRC_PC]     = {8'h00, pc_lsb};
    assign src_bus[SRC_ALUOUT] = {8'h00, aluout_lsb};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign nibble[gi] = snapshot_reg[4*gi +: 4];
        end
        for (gi = 0; gi < 8; gi++) begin : g_led
            assign src_led_next[gi] = (src_idx_reg == src_idx_t'(gi));
        end
    endgenerate

    assign refresh_wrap = &refresh_cnt_reg;
    // Last cycle of digit 3: the digit index returns to 0 on this edge, which is
    // also where a fresh snapshot is taken so the next scan is coherent.
    assign scan_wrap    = refresh_wrap && (digit_idx_reg == 2'd3);
    assign wide_view    = (src_idx_reg >= SRC_PC);

    always_comb begin
        seg_next = hex_to_seg(nibble[digit_idx_reg]);
        dp_next  = 1'b1;
        // 8-bit sources: upper two digits blank, dp on digit 0 flags the view.
        if (wide_view && digit_idx_reg[1]) begin
            seg_next = SEG_BLANK;
        end
        if (wide_view && (digit_idx_reg == 2'd0)) begin
            dp_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= 2'd0;
            src_idx_reg     <= SRC_CTRL;
            snapshot_reg    <= 16'h0000;
            first_cycle_reg <= 1'b1;
            an_reg          <= AN_ALL_OFF;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
            src_led_reg     <= 8'h01;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
            first_cycle_reg <= 1'b0;
            if (refresh_wrap) begin
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end
            if (btn_rise) begin
                src_idx_reg <= src_idx_reg + 3'd1;
            end
            // Uses the pre-increment index when a press lands on the same edge.
            if (first_cycle_reg || scan_wrap) begin
                snapshot_reg <= src_bus[src_idx_reg];
            end
            an_reg      <= ~(4'b0001 << digit_idx_reg);
            seg_reg     <= seg_next;
            dp_reg      <= dp_next;
            src_led_reg <= src_led_next;
        end
    end

    assign an      = an_reg;
    assign seg     = seg_reg;
    assign dp      = dp_reg;
    assign src_led = src_led_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel_btn = 1'b0;
    logic [15:0] ctrl_sig = 16'h0;
    logic [15:0] instr_lsh = 16'h0;
    logic [15:0] rs_lsh = 16'h1111;
    logic [15:0] rt_lsh = 16'h2222;
    logic [15:0] rdata_lsh = 16'h3333;
    logic [15:0] rfin_lsh = 16'h4444;
    logic [7:0]  pc_lsb = 8'h0;
    logic [7:0]  aluout_lsb = 8'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [7:0]  src_led;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] led_q[$];
    logic [6:0] hex_tbl [16];
    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    int         exp_src = 0;

    display_scan_ctrl #(
        .REFRESH_BITS   (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_btn   (sel_btn),
        .ctrl_sig  (ctrl_sig),
        .instr_lsh (instr_lsh),
        .rs_lsh    (rs_lsh),
        .rt_lsh    (rt_lsh),
        .rdata_lsh (rdata_lsh),
        .rfin_lsh  (rfin_lsh),
        .pc_lsb    (pc_lsb),
        .aluout_lsb(aluout_lsb),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .src_led   (src_led)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge k the outputs show digit ((k-1)/4)%4.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align_scan();
        for (int n = 0; n < 16 && (cyc % 16) != 0; n++) step();
        compared++;
        if ((cyc % 16) != 0) begin
            mismatched++;
            $display("FAIL align_scan: cyc%%16=%0d required 0", cyc % 16);
        end
    endtask

    task automatic check_led(input string name);
        logic [7:0] e;
        e = led_q.pop_front();
        compared++;
        if (src_led !== e) begin
            mismatched++;
            $display("FAIL %s src_led: got %02h required %02h", name, src_led, e);
        end
        $display("%s: src_led=%02h expected=%02h", name, src_led, e);
    endtask

    // One full 16-cycle scan starting at a scan boundary. 'first' marks the scan
    // right after reset, whose first cycle still decodes the cleared snapshot.
    task automatic scan_check(input logic [15:0] val, input int src, input bit first,
                              input int change_at, input logic [15:0] new_ctrl,
                              input int btn_hold, input string name);
        exp_t        e;
        logic [15:0] v;
        int          d;
        for (int i = 0; i < 16; i++) begin
            d = i / 4;
            v = (first && i == 0) ? 16'h0000 : val;
            e.an  = ~(4'b0001 << d);
            e.seg = (src >= 6 && d >= 2) ? 7'b1111111 : hex_tbl[v[4*d +: 4]];
            e.dp  = (src >= 6 && d == 0) ? 1'b0 : 1'b1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            sel_btn = (i < btn_hold);
            step();
            if (i == change_at) ctrl_sig = new_ctrl;
            e = exp_q.pop_front();
            compared += 3;
            if (an !== e.an) begin
                mismatched++;
                $display("FAIL %s an[%0d]: got %b required %b", name, i, an, e.an);
            end
            if (seg !== e.seg) begin
                mismatched++;
                $display("FAIL %s seg[%0d]: got %b required %b", name, i, seg, e.seg);
            end
            if (dp !== e.dp) begin
                mismatched++;
                $display("FAIL %s dp[%0d]: got %b required %b", name, i, dp, e.dp);
            end
        end
        sel_btn = 1'b0;
        $display("%s: scan of %04h src=%0d checked", name, val, src);
    endtask

    task automatic press(input string name);
        sel_btn = 1'b1;
        repeat (8) step();
        sel_btn = 1'b0;
        repeat (8) step();
        exp_src = (exp_src + 1) % 8;
        led_q.push_back(8'h01 << exp_src);
        check_led(name);
    endtask

    task automatic check_reset_vals(input string name);
        compared += 4;
        if (an !== 4'b1111) begin
            mismatched++; $display("FAIL %s an: got %b required 1111", name, an);
        end
        if (seg !== 7'b1111111) begin
            mismatched++; $display("FAIL %s seg: got %b required 1111111", name, seg);
        end
        if (dp !== 1'b1) begin
            mismatched++; $display("FAIL %s dp: got %b required 1", name, dp);
        end
        if (src_led !== 8'h01) begin
            mismatched++; $display("FAIL %s src_led: got %02h required 01", name, src_led);
        end
        $display("%s: an=%b seg=%b dp=%b src_led=%02h", name, an, seg, dp, src_led);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_sig = 16'h1234;
        repeat (3) step();
        check_reset_vals("reset_held");
    endtask

    task automatic test_first_scan();
        ctrl_sig = 16'hA5F0;
        reset = 1'b0;
        exp_src = 0;
        scan_check(16'hA5F0, 0, 1'b1, -1, 16'h0, 0, "first_scan");
        led_q.push_back(8'h01);
        check_led("first_scan");
    endtask

    task automatic test_mid_scan_change();
        scan_check(16'hA5F0, 0, 1'b0, 6, 16'h0000, 0, "mid_change_old");
        scan_check(16'h0000, 0, 1'b0, -1, 16'h0, 0, "mid_change_new");
    endtask

    task automatic test_bounce();
        instr_lsh = 16'hBEEF;
        for (int p = 0; p < 3; p++) begin
            sel_btn = 1'b1;
            repeat (3) step();
            sel_btn = 1'b0;
            step();
        end
        sel_btn = 1'b1;
        repeat (10) step();
        sel_btn = 1'b0;
        repeat (10) step();
        exp_src = 1;
        led_q.push_back(8'h02);
        check_led("bounce");
        align_scan();
        scan_check(16'hBEEF, 1, 1'b0, -1, 16'h0, 0, "bounce_instr");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        exp_src = 0;
    endtask

    task automatic test_pc_view();
        do_reset();
        pc_lsb = 8'h3C;
        for (int p = 0; p < 6; p++) press("pc_press");
        align_scan();
        scan_check({8'h00, pc_lsb}, 6, 1'b0, -1, 16'h0, 0, "pc_view");
    endtask

    task automatic test_wrap();
        aluout_lsb = 8'hE7;
        press("wrap_to7");
        align_scan();
        scan_check({8'h00, aluout_lsb}, 7, 1'b0, -1, 16'h0, 0, "alu_view");
        press("wrap_to0");
    endtask

    task automatic test_reset_mid();
        press("pre_reset");
        ctrl_sig = 16'h7C2E;
        align_scan();
        repeat (8) step();
        sel_btn = 1'b1;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        repeat (2) step();
        reset = 1'b0;
        exp_src = 0;
        // Button stays high for three more samples: a stale partial count would
        // complete here and produce a spurious increment.
        scan_check(16'h7C2E, 0, 1'b1, -1, 16'h0, 3, "restart_scan");
        repeat (4) step();
        led_q.push_back(8'h01);
        check_led("no_spurious");
    endtask

    initial begin
        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        test_reset();
        test_first_scan();
        test_mid_scan_change();
        test_bounce();
        test_pc_view();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Seven-segment display front end for the BASYS2 processor demo. It sits directly downstream of the processor top.
- Consumes the six 16-bit and two 8-bit debug outputs (ControlSignals, Instr_LSH, Rs_LSH, Rt_LSH, ReadData_LSH, RF_indata_LSH, PC_LSB, ALUOut_LSB).
- A debounced push-button steps through these eight sources. The selected value is multiplexed onto the 4-digit common-anode display as hex.

Parameters:
- REFRESH_BITS, 16, width of per-digit refresh counter; each digit is lit for 2^REFRESH_BITS cycles.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a button level change (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sel_btn  in  1  raw source-select push-button, active-high, asynchronous to clk
- ctrl_sig  in  16  ControlSignals
- instr_lsh  in  16  Instr_LSH
- rs_lsh  in  16  Rs_LSH
- rt_lsh  in  16  Rt_LSH
- rdata_lsh  in  16  ReadData_LSH
- rfin_lsh  in  16  RF_indata_LSH
- pc_lsb  in  8  PC_LSB
- aluout_lsb  in  8  ALUOut_LSB
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  anodes, active-low; an[0] is the rightmost digit
- src_led  out  8  one-hot indication of the selected source

Behaviour:
- Reset is asynchronous and active-high. All state clears immediately on assertion:
  - refresh counter = 0, digit index = 0, source index = 0
  - snapshot register = 16'h0000, debouncer state = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1, src_led = 8'h01
- Synchronizer: sel_btn passes through a 2-FF synchronizer, reset to 0.
- Debouncer:
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current level.
  - Any sample equal to the current level clears the stability count.
- Source index:
  - 3 bits. Increments on a rising edge of the debounced level; wraps 7 -> 0.
  - Falling edges have no effect.
  - Holding the button gives exactly one increment.
- Source map:
  - 0 ctrl_sig, 1 instr_lsh, 2 rs_lsh, 3 rt_lsh, 4 rdata_lsh, 5 rfin_lsh
  - 6 {8'h00, pc_lsb}, 7 {8'h00, aluout_lsb}
- Refresh and scan:
  - The refresh counter is REFRESH_BITS wide.
  - When it wraps to 0, the digit index advances 0 -> 1 -> 2 -> 3 -> 0.
- Snapshot:
  - The selected source is captured into the snapshot register on the cycle the digit index advances 3 -> 0, and also on the first cycle after reset release.
  - All four digits of one scan therefore show one coherent value.
  - A source change or data change becomes visible at the next snapshot. Latency is at most 4·2^REFRESH_BITS cycles.
- Outputs (registered, one cycle after the digit index updates):
  - an = ~(4'b0001 << digit index).
  - seg = hex decode of snapshot nibble [4·digit+3 : 4·digit].
  - Hex patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Blanking: for source index 6 or 7, digits 2 and 3 show seg = 1111111 (anode still cycles).
  - dp is 0 on digit 0 only while the source index is 6 or 7 (marks the 8-bit view); otherwise dp = 1.
  - src_led = 8'h01 << source index, updated one cycle after the index changes.
- Simultaneous events:
  - A button edge in the same cycle as a snapshot: the snapshot uses the old index; the new index appears at the next snapshot.
- Reset mid-scan or mid-debounce:
  - All state returns to the reset values above. A partially counted debounce is discarded.

Decomposition:
- Shared package display_pkg:
  - SEG_BLANK and the 16 hex segment constants
  - source index localparams SRC_CTRL through SRC_ALUOUT
  - an all-off constant
- One natural sub-module, button_debounce: 2-FF synchronizer, stability counter, debounced level, rising-edge pulse output. Parameterised by DEBOUNCE_CYCLES.

Test Plan (REFRESH_BITS=2, DEBOUNCE_CYCLES=4):
- Reset held, ctrl_sig=16'h1234 -> an=1111, seg=1111111, dp=1, src_led=01.
- Release reset, ctrl_sig=16'hA5F0 -> in one full scan, an sequence 1110/1101/1011/0111 with seg 1000000 (0), 0001110 (F), 0010010 (5), 0001000 (A); each digit held 4 cycles.
- Mid-scan, change ctrl_sig to 16'h0000 -> the remaining digits of the current scan still show A5F0 nibbles; the next scan shows all 1000000.
- sel_btn bounce: 3-cycle pulses separated by 1 cycle low, then held high 10 cycles -> source index increments exactly once; src_led=02; next scan shows instr_lsh.
- Press 6 times from index 0, pc_lsb=8'h3C -> src_led=40; digits 0/1 show C/3; digits 2/3 blank; dp=0 on digit 0 only. Two more presses wrap to index 0 (src_led=01).
- Assert reset mid-debounce (2 stable samples) and mid-scan at digit 2 -> immediate reset values; after release, no spurious increment and the scan restarts at digit 0.
